// File: rtl/rs_cu_v2.sv
// Control unit for the 20-bit restoring square-root datapath: sequences 10 CALC/TEST digit steps, then OUT and DONE.
// Optional feature: define RS_CU_ABORT_EN to add the abort input and the aborted pulse output.
module rs_cu_v2 #(
   parameter int ITERS = 10,
   parameter int CNT_W = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic bsign,
   input  logic neq0,
`ifdef RS_CU_ABORT_EN
   input  logic abort,
   output logic aborted,
`endif
   output logic busy,
   output logic done,
   output logic err,
   output logic ldn,
   output logic lda,
   output logic ldt,
   output logic ldp,
   output logic ldb,
   output logic ldq,
   output logic selq,
   output logic ldm,
   output logic selm,
   output logic decn,
   output logic ldo
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CALC = 3'd1,
      S_TEST = 3'd2,
      S_OUT  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   typedef struct packed {
      logic ldn;
      logic lda;
      logic ldt;
      logic ldp;
      logic ldb;
      logic ldq;
      logic selq;
      logic ldm;
      logic selm;
      logic decn;
      logic ldo;
   } strb_t;

   localparam logic [CNT_W-1:0] ITERS_N = CNT_W'(ITERS);
   localparam logic [CNT_W:0]   ITERS_W = (CNT_W+1)'(ITERS);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic               aborted_q, abort_hit;
   strb_t              strb;
   logic               busy_d, done_d;
   logic [CNT_W:0]     cnt_inc;
   logic               last_iter, seq_err;

   // Sequencing check: the datapath's n==0 must coincide with the final counted digit.
   assign cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
   assign last_iter = (cnt_inc == ITERS_W);
   assign seq_err   = (neq0 && !last_iter) || (last_iter && !neq0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      abort_hit = 1'b0;
      strb      = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               strb.ldn = 1'b1;
               strb.lda = 1'b1;
               cnt_d    = '0;
               err_d    = 1'b0;
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            busy_d   = 1'b1;
            strb.ldp = 1'b1;
            strb.ldb = 1'b1;
            strb.ldt = 1'b1;
            state_d  = S_TEST;
         end
         S_TEST: begin
            busy_d    = 1'b1;
            strb.ldq  = 1'b1;
            strb.ldm  = 1'b1;
            strb.selq = bsign;
            strb.selm = bsign;
            strb.decn = !neq0;
            cnt_d     = (cnt_q == ITERS_N) ? cnt_q : cnt_q + CNT_W'(1);
            if (seq_err) begin
               err_d = 1'b1;
            end
            state_d = (neq0 || seq_err) ? S_OUT : S_CALC;
         end
         S_OUT: begin
            busy_d   = 1'b1;
            strb.ldo = 1'b1;
            state_d  = S_DONE;
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
`ifdef RS_CU_ABORT_EN
      // Abort cancels the step outright: no strobe this cycle, counter and err untouched.
      if (abort && (state_q == S_CALC || state_q == S_TEST || state_q == S_OUT)) begin
         abort_hit = 1'b1;
         strb      = '0;
         state_d   = S_IDLE;
         cnt_d     = cnt_q;
         err_d     = err_q;
      end
`endif
      if (reset) begin
         strb   = '0;
         busy_d = 1'b0;
         done_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         aborted_q <= abort_hit;
      end
   end

   assign busy = busy_d;
   assign done = done_d;
   assign err  = err_q;
   assign ldn  = strb.ldn;
   assign lda  = strb.lda;
   assign ldt  = strb.ldt;
   assign ldp  = strb.ldp;
   assign ldb  = strb.ldb;
   assign ldq  = strb.ldq;
   assign selq = strb.selq;
   assign ldm  = strb.ldm;
   assign selm = strb.selm;
   assign decn = strb.decn;
   assign ldo  = strb.ldo;

`ifdef RS_CU_ABORT_EN
   assign aborted = aborted_q;
`else
   logic unused_aborted;
   assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_rs_cu_v2.sv
// Bench for rs_cu_v2: a small square-root datapath stand-in driven by the strobes, plus a phase-level reference model.
module tb_rs_cu_v2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic busy, done, err;
   logic ldn, lda, ldt, ldp, ldb, ldq, selq, ldm, selm, decn, ldo;
   logic bsign, neq0;
`ifdef RS_CU_ABORT_EN
   logic abort = 1'b0;
   logic aborted;
`endif

   rs_cu_v2 #(.ITERS(10), .CNT_W(4)) dut (
      .clock(clock), .reset(reset), .start(start), .bsign(bsign), .neq0(neq0),
`ifdef RS_CU_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .busy(busy), .done(done), .err(err),
      .ldn(ldn), .lda(lda), .ldt(ldt), .ldp(ldp), .ldb(ldb), .ldq(ldq),
      .selq(selq), .ldm(ldm), .selm(selm), .decn(decn), .ldo(ldo)
   );

   always #5 clock = ~clock;

   // Datapath stand-in: accept root bit n when a - (q | 2^n)^2 is non-negative.
   logic [19:0]        data_in   = '0;
   logic [19:0]        a_r       = '0;
   logic [9:0]         q_r       = '0;
   logic [9:0]         data_out  = '0;
   logic [3:0]         n_r       = 4'd9;
   logic signed [21:0] b_r       = '0;
   logic               force_neq0 = 1'b0;

   function automatic logic [19:0] sq(input logic [9:0] v);
      return {10'd0, v} * {10'd0, v};
   endfunction

   always @(posedge clock) begin
      if (lda) begin
         a_r <= data_in;
         q_r <= '0;
      end
      if (ldn) n_r <= 4'd9;
      if (ldb) b_r <= $signed({2'b00, a_r}) - $signed({2'b00, sq(q_r | (10'd1 << n_r))});
      if (ldq && n_r < 4'd10) q_r[n_r] <= ~selq;
      if (decn) n_r <= n_r - 4'd1;
      if (ldo) data_out <= q_r;
   end

   assign bsign = b_r[21];
   assign neq0  = (n_r == 4'd0) || force_neq0;

   int tests = 0;
   int fails = 0;

   function automatic int isqrt_ref(input int x);
      int r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: phase 0 = idle, 1..20 alternate calc/test, 21 = out, 22 = done.
   bit chk_en    = 1'b0;
   int phase     = 0;
   bit err_m     = 1'b0;
   bit aborted_m = 1'b0;
   int exp_q     = 0;

   always @(negedge clock) begin
      bit is_calc, is_test, abort_now, e;
      logic [13:0] exp_v, act_v;
      int it;
      if (chk_en) begin
         is_calc   = (phase >= 1) && (phase <= 19) && (phase % 2 == 1);
         is_test   = (phase >= 2) && (phase <= 20) && (phase % 2 == 0);
         abort_now = 1'b0;
`ifdef RS_CU_ABORT_EN
         abort_now = abort && (phase >= 1) && (phase <= 21);
`endif
         exp_v = '0;
         exp_v[11] = err_m;
         if (!reset) begin
            exp_v[13] = (phase >= 1) && (phase <= 21);
            exp_v[12] = (phase == 22);
            if (!abort_now) begin
               exp_v[10] = (phase == 0) && start;
               exp_v[9]  = (phase == 0) && start;
               exp_v[8]  = is_calc;
               exp_v[7]  = is_calc;
               exp_v[6]  = is_calc;
               exp_v[5]  = is_test;
               exp_v[4]  = is_test && bsign;
               exp_v[3]  = is_test;
               exp_v[2]  = is_test && bsign;
               exp_v[1]  = is_test && !neq0;
               exp_v[0]  = (phase == 21);
            end
         end
         act_v = {busy, done, err, ldn, lda, ldt, ldp, ldb, ldq, selq, ldm, selm, decn, ldo};
         tests++;
         if (act_v !== exp_v) begin
            fails++;
            $display("FAIL outputs phase=%0d: got %b expected %b", phase, act_v, exp_v);
         end
`ifdef RS_CU_ABORT_EN
         tests++;
         if (aborted !== aborted_m) begin
            fails++;
            $display("FAIL aborted phase=%0d: got %b expected %b", phase, aborted, aborted_m);
         end
`endif
         if (phase == 22 && !err_m && !reset) begin
            tests++;
            if (int'(data_out) != exp_q) begin
               fails++;
               $display("FAIL data_out: got %0d expected %0d", data_out, exp_q);
            end
         end
         aborted_m = abort_now && !reset;
         if (reset) begin
            phase = 0;
            err_m = 1'b0;
         end else if (abort_now) begin
            phase = 0;
         end else if (phase == 0) begin
            if (start) begin
               phase = 1;
               err_m = 1'b0;
               exp_q = isqrt_ref(int'(data_in));
            end
         end else if (is_calc) begin
            phase++;
         end else if (is_test) begin
            it = phase / 2;
            e  = (neq0 && it != 10) || (!neq0 && it == 10);
            if (e) err_m = 1'b1;
            if (e || neq0) phase = 21;
            else phase++;
         end else if (phase == 21) begin
            phase = 22;
         end else begin
            phase = 0;
         end
      end
   end

   task automatic run_op(input logic [19:0] din, input int exp_val, input string tag);
      int cnt = 0;
      int bcnt = 0;
      bit seen = 1'b0;
      @(posedge clock); #1;
      data_in = din;
      start   = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clock);
         if (busy) bcnt++;
         if (done) begin
            seen = 1'b1;
            cnt  = i;
         end
      end
      if (!seen) begin
         chk({tag, "_timeout"}, 0, 1);
      end else begin
         chk({tag, "_lat"}, cnt - 1, 21);
         chk({tag, "_busy"}, bcnt, 21);
         chk({tag, "_data"}, int'(data_out), exp_val);
         chk({tag, "_err"}, int'(err), 0);
      end
   endtask

   task automatic start_only(input logic [19:0] din);
      @(posedge clock); #1;
      data_in = din;
      start   = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic count_done(input int n, output int c);
      c = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (done) c++;
      end
   endtask

   initial begin
      int c;
      logic [9:0] held;
      @(posedge clock); #1;
      chk_en = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_strobes", int'({ldn, lda, ldt, ldp, ldb, ldq, selq, ldm, selm, decn, ldo}), 0);

      chk("ref_144", isqrt_ref(144), 12);
      chk("ref_max", isqrt_ref(1048575), 1023);
      chk("ref_1e6", isqrt_ref(1000000), 1000);
      chk("ref_2", isqrt_ref(2), 1);

      run_op(20'd144, 12, "op144");
      run_op(20'd1048575, 1023, "opmax");
      run_op(20'd0, 0, "opzero");

      // Start held high: accepted only from idle, one operation at a time.
      @(posedge clock); #1;
      data_in = 20'd1000000;
      start   = 1'b1;
      @(posedge clock);
      count_done(70, c);
      chk("held_dones", c, 3);
      chk("held_data", int'(data_out), 1000);
      #1 start = 1'b0;
      count_done(30, c);
      chk("held_tail_done", c, 1);

      // Premature n==0 at the third digit test.
      start_only(20'd144);
      repeat (5) @(posedge clock);
      #1 force_neq0 = 1'b1;
      @(posedge clock); #1;
      force_neq0 = 1'b0;
      @(negedge clock);
      chk("seqerr_err", int'(err), 1);
      chk("seqerr_ldo", int'(ldo), 1);
      @(negedge clock);
      chk("seqerr_done", int'(done), 1);
      chk("seqerr_sticky", int'(err), 1);
      run_op(20'd2, 1, "op2");

      // Reset during the fifth digit test abandons the operation.
      start_only(20'd144);
      repeat (9) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("midrst_outs", int'({busy, done, err, ldn, lda, ldt, ldp, ldb, ldq, selq, ldm, selm, decn, ldo}), 0);
      count_done(30, c);
      chk("midrst_no_done", c, 0);
      run_op(20'd144, 12, "op144b");

`ifdef RS_CU_ABORT_EN
      held = data_out;
      start_only(20'd1048575);
      repeat (5) @(posedge clock);
      #1 abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
      @(negedge clock);
      chk("abort_pulse", int'(aborted), 1);
      chk("abort_busy", int'(busy), 0);
      count_done(30, c);
      chk("abort_no_done", c, 0);
      chk("abort_data", int'(data_out), int'(held));
`else
      held = data_out;
      chk("final_data", int'(held), 12);
`endif

      repeat (3) @(posedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
